// File: rtl/btt_pkg.sv
// btt_pkg: shared defaults, load FSM state encoding and target word type
// for the branch target table.
//   ADDR_W_DEF    - default entry pointer width (DEPTH = 2**ADDR_W)
//   TGT_W_DEF     - default target (PC) width
//   NUM_BANKS_DEF - default number of program banks
//   bank_w()      - bank select width, never less than 1
package btt_pkg;
    localparam int ADDR_W_DEF    = 5;
    localparam int TGT_W_DEF     = 10;
    localparam int NUM_BANKS_DEF = 4;
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} btt_state_t;
    typedef logic [TGT_W_DEF-1:0] tgt_t;
    function automatic int bank_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/branch_target_table_if.sv
// branch_target_table_if: read and load ports of the branch target table.
//   read : bank_sel, rd_en, rd_addr -> rd_target, rd_valid, rd_miss
//   load : load_start, load_bank, load_last, ld_valid, ld_data
//          -> ld_ready, load_busy, load_done
//   stats: hit_cnt, miss_cnt (only with BTT_STATS_EN defined)
//   master = fetch stage / loader, slave = table.
interface branch_target_table_if #(
    parameter int ADDR_W    = btt_pkg::ADDR_W_DEF,
    parameter int TGT_W     = btt_pkg::TGT_W_DEF,
    parameter int NUM_BANKS = btt_pkg::NUM_BANKS_DEF
);
    import btt_pkg::*;
    localparam int BANK_W = bank_w(NUM_BANKS);
    logic [BANK_W-1:0] bank_sel;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [TGT_W-1:0]  rd_target;
    logic              rd_valid;
    logic              rd_miss;
    logic              load_start;
    logic [BANK_W-1:0] load_bank;
    logic [ADDR_W-1:0] load_last;
    logic              ld_valid;
    logic [TGT_W-1:0]  ld_data;
    logic              ld_ready;
    logic              load_busy;
    logic              load_done;
`ifdef BTT_STATS_EN
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;
    modport master (
        output bank_sel, rd_en, rd_addr, load_start, load_bank, load_last, ld_valid, ld_data,
        input  rd_target, rd_valid, rd_miss, ld_ready, load_busy, load_done, hit_cnt, miss_cnt
    );
    modport slave (
        input  bank_sel, rd_en, rd_addr, load_start, load_bank, load_last, ld_valid, ld_data,
        output rd_target, rd_valid, rd_miss, ld_ready, load_busy, load_done, hit_cnt, miss_cnt
    );
`else
    modport master (
        output bank_sel, rd_en, rd_addr, load_start, load_bank, load_last, ld_valid, ld_data,
        input  rd_target, rd_valid, rd_miss, ld_ready, load_busy, load_done
    );
    modport slave (
        input  bank_sel, rd_en, rd_addr, load_start, load_bank, load_last, ld_valid, ld_data,
        output rd_target, rd_valid, rd_miss, ld_ready, load_busy, load_done
    );
`endif
endinterface

// File: rtl/btt_load_fsm.sv
// btt_load_fsm: load sequencer for one bank of the branch target table.
//   in : Clk, Reset_n (async, active-low), load_start, load_bank, load_last, ld_valid
//   out: ld_ready, load_busy, load_done,
//        clr (clear valid bits of bank), wr_en (write ld_data at bank/idx),
//        bank (captured bank), idx (write index)
module btt_load_fsm
    import btt_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BANK_W = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load_start,
    input  logic [BANK_W-1:0] load_bank,
    input  logic [ADDR_W-1:0] load_last,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              clr,
    output logic              wr_en,
    output logic [BANK_W-1:0] bank,
    output logic [ADDR_W-1:0] idx
);
    btt_state_t state, state_nx;
    logic [ADDR_W-1:0] last;

    assign ld_ready  = state == LOAD;
    assign load_busy = state != IDLE;
    assign load_done = state == DONE;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            idx   <= '0;
            bank  <= '0;
            last  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && load_start) begin
                bank <= load_bank;
                last <= load_last;
                idx  <= '0;
            end else if (wr_en && idx != last) begin
                // Hold on the final beat so a full-depth load never wraps idx.
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        wr_en    = 1'b0;
        case (state)
            IDLE:  state_nx = load_start ? CLEAR : IDLE;
            CLEAR: begin
                clr      = 1'b1;
                state_nx = LOAD;
            end
            LOAD: begin
                wr_en    = ld_valid;
                state_nx = (ld_valid && idx == last) ? DONE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: rtl/branch_target_table.sv
// branch_target_table: multi-bank run-time-loadable PC branch target table.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   bus (slave)  : read port with 1-cycle registered result, valid/ready
//                  load port driven by btt_load_fsm
// Optional: define BTT_STATS_EN to add saturating 16-bit hit_cnt/miss_cnt,
// cleared by reset and by load_done.
module branch_target_table
    import btt_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int TGT_W     = TGT_W_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF
) (
    input logic                  Clk,
    input logic                  Reset_n,
    branch_target_table_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BANK_W = bank_w(NUM_BANKS);

    logic [TGT_W-1:0]                 mem [NUM_BANKS][DEPTH];
    logic [NUM_BANKS-1:0][DEPTH-1:0]  vld;
    logic                             clr, wr_en, hit;
    logic [BANK_W-1:0]                wr_bank;
    logic [ADDR_W-1:0]                wr_idx;

    btt_load_fsm #(.ADDR_W(ADDR_W), .BANK_W(BANK_W)) u_fsm (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load_start (bus.load_start),
        .load_bank  (bus.load_bank),
        .load_last  (bus.load_last),
        .ld_valid   (bus.ld_valid),
        .ld_ready   (bus.ld_ready),
        .load_busy  (bus.load_busy),
        .load_done  (bus.load_done),
        .clr        (clr),
        .wr_en      (wr_en),
        .bank       (wr_bank),
        .idx        (wr_idx)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            vld <= '0;
        else if (clr)
            vld[wr_bank] <= '0;
        else if (wr_en)
            vld[wr_bank][wr_idx] <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_bank][wr_idx] <= bus.ld_data;
    end

    // Sampled before this edge's write lands, so a same-entry read sees old data.
    assign hit = vld[bus.bank_sel][bus.rd_addr];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.rd_target <= '0;
            bus.rd_valid  <= 1'b0;
            bus.rd_miss   <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_target <= hit ? mem[bus.bank_sel][bus.rd_addr] : '0;
                bus.rd_miss   <= !hit;
            end
        end
    end

`ifdef BTT_STATS_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.hit_cnt  <= '0;
            bus.miss_cnt <= '0;
        end else if (bus.load_done) begin
            bus.hit_cnt  <= '0;
            bus.miss_cnt <= '0;
        end else if (bus.rd_valid) begin
            if (!bus.rd_miss && bus.hit_cnt != 16'hFFFF)
                bus.hit_cnt <= bus.hit_cnt + 16'd1;
            if (bus.rd_miss && bus.miss_cnt != 16'hFFFF)
                bus.miss_cnt <= bus.miss_cnt + 16'd1;
        end
    end
`endif
endmodule
